// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if
// Bundles the core-side message/payload handshakes, the router credit-return
// lines and the outgoing flit bus of the NI transmit packetizer.
//   msg_*      descriptor handshake (valid/ready, dst_x, dst_y, vc, len)
//   data_*     payload word handshake (valid/ready, data_in)
//   credit_in  per-VC one-cycle credit-return pulses from the router
//   flit_out   registered flit towards the router local_in port
// Modports:
//   master  the environment side: core and router credit return
//   slave   the packetizer itself
interface ni_packetizer_if #(
  parameter int x_size     = 4,
  parameter int y_size     = 4,
  parameter int DATA_WIDRH = 64,
  parameter int FLIT_WIDRH = 80,
  parameter int NUM_VC     = 5,
  parameter int MAX_LEN    = 16
);
  localparam int XW = $clog2(x_size);
  localparam int YW = $clog2(y_size);
  localparam int LW = $clog2(MAX_LEN) + 1;

  logic                  msg_valid;
  logic                  msg_ready;
  logic [XW-1:0]         msg_dst_x;
  logic [YW-1:0]         msg_dst_y;
  logic [2:0]            msg_vc;
  logic [LW-1:0]         msg_len;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDRH-1:0] data_in;
  logic [NUM_VC-1:0]     credit_in;
  logic [FLIT_WIDRH-1:0] flit_out;

  modport master (
    output msg_valid, msg_dst_x, msg_dst_y, msg_vc, msg_len,
    output data_valid, data_in, credit_in,
    input  msg_ready, data_ready, flit_out
  );

  modport slave (
    input  msg_valid, msg_dst_x, msg_dst_y, msg_vc, msg_len,
    input  data_valid, data_in, credit_in,
    output msg_ready, data_ready, flit_out
  );
endinterface

// File: rtl/ni_packetizer.sv
// ni_packetizer
// NI transmit block: turns a message descriptor plus a stream of payload
// words into one head flit followed by body flits and a final tail flit,
// driving the router local_in port. Emission is gated by per-VC credit
// counters that mirror the router input FIFO depth.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   id_x, id_y  own mesh coordinates, carried in the head flit
//   bus         ni_packetizer_if.slave (descriptor, payload, credits, flit_out)
//   busy        high whenever the FSM is not IDLE
//   err_len     one-cycle pulse when a descriptor with an illegal length is accepted
//   pkt_count   packets fully sent (wraps)
module ni_packetizer #(
  parameter int x_size     = 4,
  parameter int y_size     = 4,
  parameter int DATA_WIDRH = 64,
  parameter int FLIT_WIDRH = 80,
  parameter int FIFO_DEPTH = 5,
  parameter int NUM_VC     = 5,
  parameter int MAX_LEN    = 16,
  localparam int XW        = $clog2(x_size),
  localparam int YW        = $clog2(y_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] id_x,
  input  logic [YW-1:0] id_y,
  ni_packetizer_if.slave bus,
  output logic          busy,
  output logic          err_len,
  output logic [15:0]   pkt_count
);
  localparam int LW    = $clog2(MAX_LEN) + 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int HOP_W = FLIT_WIDRH - 2 - XW - YW - NUM_VC - DATA_WIDRH;

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

  state_t                state, state_nxt;
  logic [XW-1:0]         dst_x_q;
  logic [YW-1:0]         dst_y_q;
  logic [2:0]            vc_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         rem_q;
  logic [CW-1:0]         credit [NUM_VC];
  logic [FLIT_WIDRH-1:0] flit_p0, flit_p1;

  logic                  accept, len_ok, has_credit, head_emit, word_emit, last_word;
  logic [NUM_VC-1:0]     vc_onehot;
  logic [1:0]            flit_type;
  logic [DATA_WIDRH-1:0] flit_data;

  // Credit update: a same-cycle return and consumption cancel, and a
  // return at full depth saturates instead of wrapping.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                 input logic dec,
                                                 input logic inc);
    if (dec && !inc)
      return cur - CW'(1);
    if (inc && !dec && (cur != CW'(FIFO_DEPTH)))
      return cur + CW'(1);
    return cur;
  endfunction

  // Credit availability on the latched VC; an out-of-range VC never has credit.
  always_comb begin
    has_credit = 1'b0;
    for (int v = 0; v < NUM_VC; v++)
      if (vc_q == 3'(v))
        has_credit = (credit[v] != '0);
  end

  assign len_ok    = (bus.msg_len != '0) && (bus.msg_len <= LW'(MAX_LEN));
  assign last_word = (rem_q == LW'(1));
  assign vc_onehot = NUM_VC'(1) << vc_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && len_ok)         state_nxt = HEAD;
      HEAD:    if (has_credit)               state_nxt = PAYLOAD;
      PAYLOAD: if (word_emit && last_word)   state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // FSM outputs; msg_ready is held low during the reset cycle itself.
  always_comb begin
    bus.msg_ready  = (state == IDLE) && !rst;
    accept         = bus.msg_ready && bus.msg_valid;
    err_len        = accept && !len_ok;
    head_emit      = (state == HEAD) && has_credit;
    bus.data_ready = (state == PAYLOAD) && bus.data_valid && has_credit;
    word_emit      = bus.data_ready;
    busy           = (state != IDLE);
  end

  // p0: flit assembly; any cycle without an emission yields an all-zero flit.
  always_comb begin
    flit_type = 2'b00;
    flit_data = '0;
    if (head_emit) begin
      flit_type = 2'b01;
      flit_data = DATA_WIDRH'({id_x, id_y, len_q});
    end else if (word_emit) begin
      flit_type = last_word ? 2'b11 : 2'b10;
      flit_data = bus.data_in;
    end
    flit_p0 = '0;
    if (head_emit || word_emit)
      flit_p0 = {flit_type, {HOP_W{1'b0}}, dst_x_q, dst_y_q, vc_onehot, flit_data};
  end

  // Descriptor and remaining-word tracking (datapath, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      dst_x_q <= bus.msg_dst_x;
      dst_y_q <= bus.msg_dst_y;
      vc_q    <= bus.msg_vc;
      len_q   <= bus.msg_len;
    end
    if (head_emit)
      rem_q <= len_q;
    else if (word_emit)
      rem_q <= rem_q - LW'(1);
  end

  // p1: registered flit; cleared on reset so a packet abandoned mid-flight
  // never leaks a partial flit.
  always_ff @(posedge clk) begin
    if (rst)
      flit_p1 <= '0;
    else
      flit_p1 <= flit_p0;
  end

  assign bus.flit_out = flit_p1;

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (rst)
        credit[v] <= CW'(FIFO_DEPTH);
      else
        credit[v] <= credit_next(credit[v],
                                 (head_emit || word_emit) && (vc_q == 3'(v)),
                                 bus.credit_in[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pkt_count <= '0;
    else if (word_emit && last_word)
      pkt_count <= pkt_count + 16'd1;
  end
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer
// Directed bench for ni_packetizer. Stimulus tasks push every expected flit
// (value and the cycle it must appear on flit_out) into a scoreboard queue;
// a negedge monitor pops and compares whenever flit_out is non-zero.
// Own coordinates are (1,3), so a head data field is {id_x=01, id_y=11, len}.
module tb_ni_packetizer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  id_x = 2'd1;
  logic [1:0]  id_y = 2'd3;
  logic        busy, err_len;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  ni_packetizer_if bus ();

  ni_packetizer dut (
    .clk       (clk),
    .rst       (rst),
    .id_x      (id_x),
    .id_y      (id_y),
    .bus       (bus),
    .busy      (busy),
    .err_len   (err_len),
    .pkt_count (pkt_count)
  );

  typedef struct {
    logic [79:0] flit;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_pkt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [79:0] mk_flit(input logic [1:0] typ, input logic [1:0] dx,
                                          input logic [1:0] dy, input logic [2:0] vc,
                                          input logic [63:0] d);
    logic [4:0] oh;
    oh = 5'b00001 << vc;
    return {typ, 5'b00000, dx, dy, oh, d};
  endfunction

  task automatic push_exp(input logic [79:0] f, input int c);
    exp_t e;
    e.flit = f;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic push_head(input logic [1:0] dx, input logic [1:0] dy,
                           input logic [2:0] vc, input logic [4:0] len, input int c);
    push_exp(mk_flit(2'b01, dx, dy, vc, {55'd0, 2'd1, 2'd3, len}), c);
  endtask

  // Monitor: every non-idle flit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.flit_out !== 80'd0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_flit: got %h, expected idle (cycle %0d)", bus.flit_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("flit_value", bus.flit_out, mon_e.flit);
        check("flit_cycle", 80'(cyc), 80'(mon_e.cyc));
      end
    end
  end

  // Presents a descriptor until accepted; t is the acceptance cycle.
  task automatic send_msg(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] vc,
                          input logic [4:0] len, output int t, output logic err);
    bit ok = 0;
    t   = -1;
    err = 1'b0;
    bus.msg_valid = 1'b1;
    bus.msg_dst_x = dx;
    bus.msg_dst_y = dy;
    bus.msg_vc    = vc;
    bus.msg_len   = len;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.msg_ready) begin
        ok  = 1;
        t   = cyc;
        err = err_len;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    bus.msg_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL msg_accept_timeout: got no msg_ready, expected acceptance");
    end
  endtask

  // Presents one payload word until accepted; cred pulses credit_in for the
  // first cycle only. The flit is expected on flit_out in cycle exp_c.
  task automatic send_word(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] vc,
                           input logic [63:0] d, input bit tail, input int exp_c,
                           input logic [4:0] cred);
    bit acc = 0;
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    bus.credit_in  = cred;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = bus.data_ready;
      @(posedge clk);
      #1;
      bus.credit_in = 5'd0;
      if (acc) break;
    end
    bus.data_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL data_accept_timeout: got no data_ready, expected acceptance");
    end else begin
      push_exp(mk_flit(tail ? 2'b11 : 2'b10, dx, dy, vc, d), exp_c);
    end
  endtask

  // Full packet with credit available: head at T+2, payload back-to-back from T+3.
  task automatic send_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic [2:0] vc,
                          input logic [4:0] len, input logic [63:0] base,
                          input int cred_idx, input logic [4:0] cred);
    int   t;
    logic err;
    send_msg(dx, dy, vc, len, t, err);
    check("err_len_legal", 80'(err), 80'(0));
    push_head(dx, dy, vc, len, t + 2);
    for (int i = 0; i < int'(len); i++)
      send_word(dx, dy, vc, base + 64'(i), (i == int'(len) - 1), t + 3 + i,
                (i == cred_idx) ? cred : 5'd0);
    exp_pkt++;
    check("pkt_count", 80'(pkt_count), 80'(exp_pkt));
  endtask

  initial begin
    int   t, p, q;
    logic err;
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, p, q;
    logic err;
    bus.msg_valid  = 1'b0;
    bus.msg_dst_x  = '0;
    bus.msg_dst_y  = '0;
    bus.msg_vc     = '0;
    bus.msg_len    = '0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.credit_in  = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_msg_ready", 80'(bus.msg_ready), 80'(0));
    check("rst_flit_out", bus.flit_out, 80'd0);
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_err_len", 80'(err_len), 80'(0));
    check("rst_data_ready", 80'(bus.data_ready), 80'(0));
    check("rst_pkt_count", 80'(pkt_count), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_msg_ready", 80'(bus.msg_ready), 80'(1));
    @(posedge clk); #1;

    // Single-word message: head at T+2, tail 0xA5 at T+3
    send_pkt(2'd2, 2'd1, 3'd0, 5'd1, 64'hA5, -1, 5'd0);

    // len=4 on vc2 uses all five credits
    send_pkt(2'd3, 2'd0, 3'd2, 5'd4, 64'h1000_0000_0000_0000, -1, 5'd0);
    // Second vc2 message stalls in HEAD until a credit returns
    send_msg(2'd1, 2'd2, 3'd2, 5'd1, t, err);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_flit_zero", bus.flit_out, 80'd0);
    check("stall_busy", 80'(busy), 80'(1));
    @(posedge clk); #1;
    bus.credit_in = 5'b00100;
    p = cyc;
    push_head(2'd1, 2'd2, 3'd2, 5'd1, p + 2);
    @(posedge clk); #1;
    bus.credit_in = 5'd0;
    bus.data_valid = 1'b1;
    bus.data_in = 64'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("vc2_no_credit_data_ready", 80'(bus.data_ready), 80'(0));
    @(posedge clk); #1;
    q = cyc;
    send_word(2'd1, 2'd2, 3'd2, 64'hBEEF, 1'b1, q + 2, 5'b00100);
    exp_pkt++;
    check("pkt_count_stall", 80'(pkt_count), 80'(exp_pkt));

    // data_valid toggling: idle gaps between words, order preserved
    send_msg(2'd0, 2'd3, 3'd1, 5'd3, t, err);
    push_head(2'd0, 2'd3, 3'd1, 5'd3, t + 2);
    for (int i = 0; i < 3; i++) begin
      send_word(2'd0, 2'd3, 3'd1, 64'hC0DE_0000 + 64'(i), (i == 2), t + 3 + 2 * i, 5'd0);
      if (i != 2) begin
        @(posedge clk); #1;
      end
    end
    exp_pkt++;
    check("pkt_count_toggle", 80'(pkt_count), 80'(exp_pkt));

    // Credit return coinciding with an emission on vc3 leaves the count
    // unchanged: 5 flits sent, one returned -> one credit left afterwards.
    send_pkt(2'd2, 2'd2, 3'd3, 5'd4, 64'h3300, 1, 5'b01000);
    send_msg(2'd1, 2'd1, 3'd3, 5'd2, t, err);
    push_head(2'd1, 2'd1, 3'd3, 5'd2, t + 2);
    bus.data_valid = 1'b1;
    bus.data_in = 64'h3400;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("vc3_credit_used_up", 80'(bus.data_ready), 80'(0));
    @(posedge clk); #1;
    q = cyc;
    send_word(2'd1, 2'd1, 3'd3, 64'h3400, 1'b0, q + 2, 5'b01000);
    q = cyc;
    send_word(2'd1, 2'd1, 3'd3, 64'h3401, 1'b1, q + 2, 5'b01000);
    exp_pkt++;
    check("pkt_count_vc3", 80'(pkt_count), 80'(exp_pkt));

    // Illegal lengths 0 and 17: err_len pulses, nothing emitted, stays IDLE
    send_msg(2'd1, 2'd1, 3'd0, 5'd0, t, err);
    check("err_len_zero", 80'(err), 80'(1));
    @(negedge clk);
    check("err_zero_busy", 80'(busy), 80'(0));
    check("err_zero_pulse_end", 80'(err_len), 80'(0));
    @(posedge clk); #1;
    send_msg(2'd1, 2'd1, 3'd0, 5'd17, t, err);
    check("err_len_17", 80'(err), 80'(1));
    @(negedge clk);
    check("err_17_busy", 80'(busy), 80'(0));
    check("err_pkt_count", 80'(pkt_count), 80'(exp_pkt));
    @(posedge clk); #1;

    // Extra credits at full depth saturate: after 5 flits vc4 is empty
    bus.credit_in = 5'b10000;
    repeat (2) @(posedge clk);
    #1;
    bus.credit_in = 5'd0;
    send_pkt(2'd0, 2'd1, 3'd4, 5'd4, 64'h4400, -1, 5'd0);
    send_msg(2'd3, 2'd3, 3'd4, 5'd1, t, err);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("sat_stall_flit_zero", bus.flit_out, 80'd0);
    check("sat_stall_busy", 80'(busy), 80'(1));
    @(posedge clk); #1;
    bus.credit_in = 5'b10000;
    p = cyc;
    push_head(2'd3, 2'd3, 3'd4, 5'd1, p + 2);
    @(posedge clk); #1;
    bus.credit_in = 5'd0;
    bus.data_valid = 1'b1;
    bus.data_in = 64'h4500;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("payload_stall_data_ready", 80'(bus.data_ready), 80'(0));
    check("payload_stall_busy", 80'(busy), 80'(1));
    check("head_seen", 80'(sb.size()), 80'(0));

    // Reset in the middle of PAYLOAD abandons the packet
    @(posedge clk); #1;
    rst = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    check("rst_cycle_msg_ready", 80'(bus.msg_ready), 80'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pkt = 0;
    @(negedge clk);
    check("mid_rst_flit_out", bus.flit_out, 80'd0);
    check("mid_rst_busy", 80'(busy), 80'(0));
    check("mid_rst_pkt_count", 80'(pkt_count), 80'(0));
    check("mid_rst_msg_ready", 80'(bus.msg_ready), 80'(1));
    @(posedge clk); #1;
    // vc2 and vc4 were empty before reset; full credit lets both stream
    send_pkt(2'd1, 2'd0, 3'd2, 5'd4, 64'h5500, -1, 5'd0);
    send_pkt(2'd3, 2'd1, 3'd4, 5'd4, 64'h6600, -1, 5'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 80'(sb.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
